swd_seq: RTL and testbench
==========================

SWD_SEQ -- requirements
Module: swd_seq

Interface
REQ-001 SHALL have parameter RETRY_W, default 8, width of retry counter and retry_limit.
REQ-002 SHALL have parameter TMO_CYC, default 4096, clk cycles allowed per SWD transfer (used only under REQ-031).
REQ-003 clk  in  1  system clock.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-006 cmd_rnw, cmd_apndp  in  1 each  read-not-write; AP(1)/DP(0).
REQ-007 cmd_addr32  in  2  address bits 3:2.
REQ-008 cmd_count  in  8  transfers in block; 0 is treated as 1.
REQ-009 retry_limit  in  RETRY_W  maximum WAIT re-issues per transfer.
REQ-010 wr_valid/wr_ready, wr_data  in/out, in  1/1, 32  write-data stream, one word per write transfer.
REQ-011 rsp_valid/rsp_ready  out/in  1/1  response handshake.
REQ-012 rsp_data, rsp_ack, rsp_perr, rsp_last  out  32, 3, 1, 1  read data (0 on writes), final ack, parity error, last response of command.
REQ-013 if_go, if_rnw, if_apndp, if_addr32, if_dwrite  out  1,1,1,2,32  drive to SWD line interface.
REQ-014 if_ack, if_dread, if_perr, if_idle  in  3,32,1,1  results from SWD line interface.

Function
REQ-015 States: IDLE, GETW, ISSUE, BUSY, EVAL, RESP.
REQ-016 IDLE: cmd_ready=1; on cmd_valid&cmd_ready latch all cmd_* and retry_limit, load remaining=max(cmd_count,1), retries=0; go to GETW if write, else ISSUE.
REQ-017 GETW: wr_ready=1; on wr_valid latch wr_data into if_dwrite, go ISSUE.
REQ-018 ISSUE: if_go=1 held until if_idle sampled 0, then if_go=0 next cycle and go BUSY.
REQ-019 BUSY: wait for if_idle=1; then go EVAL; if_dread/if_ack/if_perr sampled in EVAL only.
REQ-020 EVAL, ack 3'b001 and perr=0: OK; decrement remaining; go RESP.
REQ-021 EVAL, ack 3'b010 (WAIT) and retries<retry_limit: retries+1, go ISSUE with same data, no response.
REQ-022 EVAL, WAIT with retries==retry_limit, ack 3'b100 (FAULT), any other ack, or perr=1: error; go RESP with rsp_last=1; remaining transfers abandoned, no write words consumed for them.
REQ-023 RESP: rsp_valid=1 until rsp_ready; rsp_last=1 when remaining==0 or error; on accept: last -> IDLE, else retries=0, GETW (write) or ISSUE (read).
REQ-024 Exactly one response per completed or failed transfer; WAIT retries produce none.
REQ-025 if_rnw/if_apndp/if_addr32 SHALL be stable from ISSUE entry until EVAL.
REQ-026 cmd_ready=0 and wr_ready=0 outside IDLE and GETW respectively.
REQ-027 rsp_valid, once high, SHALL not drop and rsp_* SHALL not change until accepted.

Reset
REQ-028 On rst: state IDLE; if_go, rsp_valid, wr_ready=0; cmd_ready=1 after release; rsp_data, if_dwrite=0; rsp_ack=3'b000; counters 0.
REQ-029 rst mid-transfer SHALL drop if_go in the same cycle; the pending command is discarded without response.
REQ-030 No state is retained across rst.

Configuration
REQ-031 SWD_SEQ_TIMEOUT_EN defined: cycle counter runs in ISSUE+BUSY; reaching TMO_CYC forces if_go=0 and error response with rsp_ack=3'b111, rsp_last=1, then IDLE after accept.
REQ-032 SWD_SEQ_TIMEOUT_EN undefined: no counter; ISSUE/BUSY wait indefinitely; 3'b111 never synthesised internally.

Structure
REQ-033 Shared package swd_pkg SHALL hold ACK_OK=3'b001, ACK_WAIT=3'b010, ACK_FAULT=3'b100, ACK_TMO=3'b111 and the state encoding.
REQ-034 No sub-module; single flat FSM plus counters.

Verification
REQ-035 Read DP addr 0, count 1, model acks 001, dread 0x2BA01477 -> one rsp, data 0x2BA01477, ack 001, last=1, perr=0.
REQ-036 Write AP, count 3, wr words 0x1,0x2,0x3 -> three if_go pulses with if_dwrite 1,2,3; three rsps ack 001, last only on third.
REQ-037 Read, retry_limit 2, model WAIT,WAIT,OK -> three issues, one rsp ack 001; with WAIT x3 -> three issues, rsp ack 010, last=1.
REQ-038 Read count 4, FAULT on second -> two rsps, second ack 100 last=1, no third issue.
REQ-039 Read with perr=1 -> rsp ack 001, perr=1, last=1; rst asserted in BUSY -> if_go=0, cmd_ready=1 after release, no rsp.
REQ-040 SWD_SEQ_TIMEOUT_EN, TMO_CYC=64, model never idles -> rsp ack 111 at cycle 64, last=1.

Source files
------------

// File: rtl/swd_pkg.sv
// Shared ack codes and FSM state encoding for the SWD transfer sequencer.
package swd_pkg;

  localparam logic [2:0] ACK_OK    = 3'b001;
  localparam logic [2:0] ACK_WAIT  = 3'b010;
  localparam logic [2:0] ACK_FAULT = 3'b100;
  localparam logic [2:0] ACK_TMO   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GETW  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_BUSY  = 3'd3,
    ST_EVAL  = 3'd4,
    ST_RESP  = 3'd5
  } swd_state_e;

endpackage

// File: rtl/swd_seq.sv
// SWD block-transfer sequencer: issues transfers to the line interface, retries WAIT acks, reports one response per transfer.
// Optional per-transfer watchdog enabled by defining SWD_SEQ_TIMEOUT_EN.
module swd_seq
  import swd_pkg::*;
#(
  parameter int RETRY_W = 8,
  parameter int TMO_CYC = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_rnw,
  input  logic               cmd_apndp,
  input  logic [1:0]         cmd_addr32,
  input  logic [7:0]         cmd_count,
  input  logic [RETRY_W-1:0] retry_limit,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [31:0]        wr_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_data,
  output logic [2:0]         rsp_ack,
  output logic               rsp_perr,
  output logic               rsp_last,
  output logic               if_go,
  output logic               if_rnw,
  output logic               if_apndp,
  output logic [1:0]         if_addr32,
  output logic [31:0]        if_dwrite,
  input  logic [2:0]         if_ack,
  input  logic [31:0]        if_dread,
  input  logic               if_perr,
  input  logic               if_idle
);

  swd_state_e         state;
  logic [7:0]         remaining;
  logic [RETRY_W-1:0] retries;
  logic [RETRY_W-1:0] limit_q;

  assign cmd_ready = (state == ST_IDLE);
  assign wr_ready  = (state == ST_GETW);
  assign rsp_valid = (state == ST_RESP);

`ifdef SWD_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  // Restarts on every issue attempt, so each retry gets its own full budget.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == ST_ISSUE || state == ST_BUSY) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign tmo_hit = (state == ST_ISSUE || state == ST_BUSY) &&
                   (tmo_cnt == TMO_W'(TMO_CYC - 1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      if_go     <= 1'b0;
      if_rnw    <= 1'b0;
      if_apndp  <= 1'b0;
      if_addr32 <= 2'b00;
      if_dwrite <= 32'h0;
      rsp_data  <= 32'h0;
      rsp_ack   <= 3'b000;
      rsp_perr  <= 1'b0;
      rsp_last  <= 1'b0;
      remaining <= 8'd0;
      retries   <= '0;
      limit_q   <= '0;
    end else begin
`ifdef SWD_SEQ_TIMEOUT_EN
      if (tmo_hit) begin
        if_go    <= 1'b0;
        rsp_data <= 32'h0;
        rsp_ack  <= ACK_TMO;
        rsp_perr <= 1'b0;
        rsp_last <= 1'b1;
        state    <= ST_RESP;
      end else
`endif
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if_rnw    <= cmd_rnw;
            if_apndp  <= cmd_apndp;
            if_addr32 <= cmd_addr32;
            limit_q   <= retry_limit;
            remaining <= (cmd_count == 8'd0) ? 8'd1 : cmd_count;
            retries   <= '0;
            if (cmd_rnw) begin
              if_go <= 1'b1;
              state <= ST_ISSUE;
            end else begin
              state <= ST_GETW;
            end
          end
        end
        ST_GETW: begin
          if (wr_valid) begin
            if_dwrite <= wr_data;
            if_go     <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!if_idle) begin
            if_go <= 1'b0;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (if_idle) begin
            state <= ST_EVAL;
          end
        end
        // A WAIT retry re-enters ISSUE with if_dwrite untouched, so the same word goes out again.
        ST_EVAL: begin
          rsp_data <= if_rnw ? if_dread : 32'h0;
          rsp_ack  <= if_ack;
          rsp_perr <= if_perr;
          if (if_ack == ACK_OK && !if_perr) begin
            remaining <= remaining - 8'd1;
            rsp_last  <= (remaining == 8'd1);
            state     <= ST_RESP;
          end else if (if_ack == ACK_WAIT && !if_perr && retries < limit_q) begin
            retries <= retries + RETRY_W'(1);
            if_go   <= 1'b1;
            state   <= ST_ISSUE;
          end else begin
            rsp_last <= 1'b1;
            state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            if (rsp_last) begin
              state <= ST_IDLE;
            end else begin
              retries <= '0;
              if (if_rnw) begin
                if_go <= 1'b1;
                state <= ST_ISSUE;
              end else begin
                state <= ST_GETW;
              end
            end
          end
        end
        default: begin
          if_go <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_swd_seq.sv
// Randomized bench for swd_seq: line-interface model plus a transaction-level expectation model.
module tb_swd_seq;
  import swd_pkg::*;

  localparam int RETRY_W = 8;
  localparam int TMO_CYC = 64;

  typedef struct packed { logic [2:0] ack; logic perr; logic [31:0] dread; } outcome_t;
  typedef struct packed { logic [31:0] data; logic [2:0] ack; logic perr; logic last; } rsp_t;
  typedef struct packed { logic rnw; logic apndp; logic [1:0] addr; logic [31:0] dwrite; } issue_t;

  logic               clk, rst;
  logic               cmd_valid, cmd_ready, cmd_rnw, cmd_apndp;
  logic [1:0]         cmd_addr32;
  logic [7:0]         cmd_count;
  logic [RETRY_W-1:0] retry_limit;
  logic               wr_valid, wr_ready;
  logic [31:0]        wr_data;
  logic               rsp_valid, rsp_ready;
  logic [31:0]        rsp_data;
  logic [2:0]         rsp_ack;
  logic               rsp_perr, rsp_last;
  logic               if_go, if_rnw, if_apndp;
  logic [1:0]         if_addr32;
  logic [31:0]        if_dwrite;
  logic [2:0]         if_ack;
  logic [31:0]        if_dread;
  logic               if_perr, if_idle;

  outcome_t    plan_q[$];
  outcome_t    script_q[$];
  logic [31:0] word_plan_q[$];
  logic [31:0] wr_word_q[$];
  rsp_t        exp_rsp_q[$];
  issue_t      exp_issue_q[$];

  int       tests_run = 0;
  int       tests_failed = 0;
  int       model_mode = 0;
  issue_t   model_exp;
  outcome_t model_out;
  rsp_t     col_exp;
  logic [36:0] col_cur, col_held;
  logic     col_held_valid;
  logic     wr_fire;

  swd_seq #(.RETRY_W(RETRY_W), .TMO_CYC(TMO_CYC)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw), .cmd_apndp(cmd_apndp),
    .cmd_addr32(cmd_addr32), .cmd_count(cmd_count), .retry_limit(retry_limit),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_ack(rsp_ack),
    .rsp_perr(rsp_perr), .rsp_last(rsp_last),
    .if_go(if_go), .if_rnw(if_rnw), .if_apndp(if_apndp), .if_addr32(if_addr32),
    .if_dwrite(if_dwrite), .if_ack(if_ack), .if_dread(if_dread), .if_perr(if_perr),
    .if_idle(if_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic outcome_t randOutcome();
    outcome_t o;
    int r;
    r = $urandom_range(9, 0);
    o.dread = $urandom;
    o.perr = ($urandom_range(15, 0) == 0);
    if (r < 6)       o.ack = ACK_OK;
    else if (r < 8)  o.ack = ACK_WAIT;
    else if (r == 8) o.ack = ACK_FAULT;
    else begin
      case ($urandom_range(2, 0))
        0:       o.ack = 3'b000;
        1:       o.ack = 3'b011;
        default: o.ack = 3'b110;
      endcase
    end
    return o;
  endfunction

  function automatic outcome_t mkOutcome(input logic [2:0] ack, input logic perr, input logic [31:0] dread);
    outcome_t o;
    o.ack = ack;
    o.perr = perr;
    o.dread = dread;
    return o;
  endfunction

  // Transaction-level reference: walks transfers, consumes one outcome per issue, predicts issues/responses/words.
  task automatic buildExpect(input logic rnw, input logic apndp, input logic [1:0] addr,
                             input logic [7:0] count, input logic [RETRY_W-1:0] limit);
    int n, retries;
    logic [31:0] w;
    outcome_t o;
    rsp_t r;
    issue_t is;
    bit stop, done_t;
    n = (count == 8'd0) ? 1 : int'(count);
    stop = 1'b0;
    for (int t = 0; t < n && !stop; t++) begin
      if (word_plan_q.size() > 0) w = word_plan_q.pop_front();
      else w = $urandom;
      if (!rnw) wr_word_q.push_back(w);
      retries = 0;
      done_t = 1'b0;
      while (!done_t) begin
        if (plan_q.size() > 0) o = plan_q.pop_front();
        else o = randOutcome();
        script_q.push_back(o);
        is.rnw = rnw; is.apndp = apndp; is.addr = addr; is.dwrite = w;
        exp_issue_q.push_back(is);
        r.data = rnw ? o.dread : 32'h0;
        r.ack = o.ack;
        r.perr = o.perr;
        if (o.ack == ACK_OK && !o.perr) begin
          r.last = (t == n - 1);
          exp_rsp_q.push_back(r);
          done_t = 1'b1;
        end else if (o.ack == ACK_WAIT && !o.perr && retries < int'(limit)) begin
          retries++;
        end else begin
          r.last = 1'b1;
          exp_rsp_q.push_back(r);
          done_t = 1'b1;
          stop = 1'b1;
        end
      end
    end
  endtask

  task automatic clearAll();
    plan_q.delete(); script_q.delete(); word_plan_q.delete();
    wr_word_q.delete(); exp_rsp_q.delete(); exp_issue_q.delete();
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    clearAll();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic sendCmd(input logic rnw, input logic apndp, input logic [1:0] addr,
                         input logic [7:0] count, input logic [RETRY_W-1:0] limit);
    int k;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rnw = rnw; cmd_apndp = apndp;
    cmd_addr32 = addr; cmd_count = count; retry_limit = limit;
    #1;
    k = 0;
    while (!cmd_ready && k < 500) begin
      @(negedge clk);
      #1;
      k++;
    end
    checkOutput("cmd_handshake", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_rnw = 1'($urandom); cmd_apndp = 1'($urandom); cmd_addr32 = 2'($urandom);
    cmd_count = 8'($urandom); retry_limit = RETRY_W'($urandom);
  endtask

  task automatic waitDone();
    int k;
    bit bad;
    k = 0;
    while (exp_rsp_q.size() > 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    #2;
    bad = (exp_rsp_q.size() != 0) || (exp_issue_q.size() != 0) || (wr_word_q.size() != 0);
    checkOutput("all_rsps_seen", 64'(exp_rsp_q.size()), 64'd0);
    checkOutput("back_to_idle", 64'(cmd_ready), 64'd1);
    checkOutput("issues_done", 64'(exp_issue_q.size()), 64'd0);
    checkOutput("words_used", 64'(wr_word_q.size()), 64'd0);
    if (bad) doReset();
  endtask

  task automatic applyStimulus(input logic rnw, input logic apndp, input logic [1:0] addr,
                               input logic [7:0] count, input logic [RETRY_W-1:0] limit);
    buildExpect(rnw, apndp, addr, count, limit);
    sendCmd(rnw, apndp, addr, count, limit);
    waitDone();
  endtask

  // mode 1: interface never accepts the go; mode 2: interface goes busy and never finishes.
  task automatic rstMidTest(input int mode);
    int k;
    model_mode = mode;
    sendCmd(1'b1, 1'b0, 2'd0, 8'd1, RETRY_W'(0));
    k = 0;
    while (!if_go && k < 50) begin @(negedge clk); k++; end
    checkOutput("rst_issue_seen", 64'(if_go), 64'd1);
    if (mode == 2) begin
      k = 0;
      while (if_go && k < 50) begin @(negedge clk); k++; end
      checkOutput("rst_busy_seen", 64'(if_go), 64'd0);
    end
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_go_drop", 64'(if_go), 64'd0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    clearAll();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_mode = 0;
    #1;
    checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    repeat (10) @(negedge clk);
    #1;
    checkOutput("rst_no_rsp", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    if_idle = 1'b1; if_ack = 3'b000; if_dread = 32'h0; if_perr = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && if_go && model_mode != 1) begin
        if (model_mode == 0) begin
          checkOutput("issue_expected", 64'(exp_issue_q.size() > 0), 64'd1);
          if (exp_issue_q.size() > 0) begin
            model_exp = exp_issue_q.pop_front();
            checkOutput("issue_rnw", 64'(if_rnw), 64'(model_exp.rnw));
            checkOutput("issue_apndp", 64'(if_apndp), 64'(model_exp.apndp));
            checkOutput("issue_addr", 64'(if_addr32), 64'(model_exp.addr));
            if (!model_exp.rnw) checkOutput("issue_dwrite", 64'(if_dwrite), 64'(model_exp.dwrite));
          end
        end
        repeat ($urandom_range(2, 0)) @(negedge clk);
        if_idle = 1'b0;
        for (int k = 0; k < 20 && if_go && !rst; k++) @(negedge clk);
        if (model_mode == 2) begin
          wait (model_mode != 2);
        end else begin
          repeat ($urandom_range(3, 0)) @(negedge clk);
          if (script_q.size() > 0) model_out = script_q.pop_front();
          else model_out = mkOutcome(ACK_FAULT, 1'b0, 32'h0);
          if_ack = model_out.ack;
          if_perr = model_out.perr;
          if_dread = model_out.dread;
        end
        if_idle = 1'b1;
      end
    end
  end

  initial begin
    wr_valid = 1'b0; wr_data = 32'h0;
    forever begin
      @(negedge clk);
      if (wr_word_q.size() > 0 && $urandom_range(3, 0) != 0) begin
        wr_valid = 1'b1;
        wr_data = wr_word_q[0];
      end else begin
        wr_valid = 1'b0;
      end
      #1 wr_fire = wr_valid && wr_ready && !rst;
      @(posedge clk);
      if (wr_fire && wr_word_q.size() > 0) void'(wr_word_q.pop_front());
    end
  end

  initial begin
    rsp_ready = 1'b0;
    col_held_valid = 1'b0;
    forever begin
      @(negedge clk);
      rsp_ready = ($urandom_range(2, 0) != 0);
      #1;
      if (!rst && rsp_valid) begin
        col_cur = {rsp_data, rsp_ack, rsp_perr, rsp_last};
        if (col_held_valid) checkOutput("rsp_stable", 64'(col_cur), 64'(col_held));
        if (rsp_ready) begin
          checkOutput("rsp_expected", 64'(exp_rsp_q.size() > 0), 64'd1);
          if (exp_rsp_q.size() > 0) begin
            col_exp = exp_rsp_q.pop_front();
            checkOutput("rsp_data", 64'(rsp_data), 64'(col_exp.data));
            checkOutput("rsp_ack", 64'(rsp_ack), 64'(col_exp.ack));
            checkOutput("rsp_perr", 64'(rsp_perr), 64'(col_exp.perr));
            checkOutput("rsp_last", 64'(rsp_last), 64'(col_exp.last));
          end
          col_held_valid = 1'b0;
        end else begin
          col_held = col_cur;
          col_held_valid = 1'b1;
        end
      end else begin
        col_held_valid = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
`ifdef SWD_SEQ_TIMEOUT_EN
    int cyc;
`endif
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_apndp = 1'b0; cmd_addr32 = 2'd0;
    cmd_count = 8'd0; retry_limit = '0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_if_go", 64'(if_go), 64'd0);
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_wr_ready", 64'(wr_ready), 64'd0);
    checkOutput("reset_rsp_data", 64'(rsp_data), 64'd0);
    checkOutput("reset_rsp_ack", 64'(rsp_ack), 64'd0);
    checkOutput("reset_if_dwrite", 64'(if_dwrite), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_cmd_ready", 64'(cmd_ready), 64'd1);

    plan_q.push_back(mkOutcome(ACK_OK, 1'b0, 32'h2BA01477));
    applyStimulus(1'b1, 1'b0, 2'd0, 8'd1, RETRY_W'(0));

    word_plan_q.push_back(32'h1); word_plan_q.push_back(32'h2); word_plan_q.push_back(32'h3);
    repeat (3) plan_q.push_back(mkOutcome(ACK_OK, 1'b0, 32'hDEAD0000));
    applyStimulus(1'b0, 1'b1, 2'd1, 8'd3, RETRY_W'(0));

    plan_q.push_back(mkOutcome(ACK_WAIT, 1'b0, 32'h0));
    plan_q.push_back(mkOutcome(ACK_WAIT, 1'b0, 32'h0));
    plan_q.push_back(mkOutcome(ACK_OK, 1'b0, 32'h12345678));
    applyStimulus(1'b1, 1'b1, 2'd2, 8'd1, RETRY_W'(2));

    repeat (3) plan_q.push_back(mkOutcome(ACK_WAIT, 1'b0, 32'h0));
    applyStimulus(1'b1, 1'b0, 2'd3, 8'd1, RETRY_W'(2));

    plan_q.push_back(mkOutcome(ACK_OK, 1'b0, 32'hA5A5A5A5));
    plan_q.push_back(mkOutcome(ACK_FAULT, 1'b0, 32'h0));
    applyStimulus(1'b1, 1'b1, 2'd1, 8'd4, RETRY_W'(0));

    plan_q.push_back(mkOutcome(ACK_OK, 1'b1, 32'hCAFEF00D));
    applyStimulus(1'b1, 1'b0, 2'd0, 8'd1, RETRY_W'(0));

    plan_q.push_back(mkOutcome(ACK_OK, 1'b0, 32'h0BADBEEF));
    applyStimulus(1'b1, 1'b0, 2'd2, 8'd0, RETRY_W'(0));

    word_plan_q.push_back(32'h55AA55AA); word_plan_q.push_back(32'h66);
    plan_q.push_back(mkOutcome(ACK_WAIT, 1'b0, 32'h0));
    plan_q.push_back(mkOutcome(ACK_OK, 1'b0, 32'h0));
    plan_q.push_back(mkOutcome(ACK_FAULT, 1'b0, 32'h0));
    applyStimulus(1'b0, 1'b0, 2'd1, 8'd3, RETRY_W'(1));

    rstMidTest(1);
    rstMidTest(2);

`ifdef SWD_SEQ_TIMEOUT_EN
    model_mode = 2;
    col_exp.data = 32'h0; col_exp.ack = ACK_TMO; col_exp.perr = 1'b0; col_exp.last = 1'b1;
    exp_rsp_q.push_back(col_exp);
    sendCmd(1'b1, 1'b0, 2'd0, 8'd2, RETRY_W'(0));
    cyc = 0;
    while (!rsp_valid && cyc < 200) begin @(negedge clk); cyc++; end
    checkOutput("tmo_cycles", 64'(cyc), 64'(TMO_CYC));
    waitDone();
    model_mode = 0;
    repeat (2) @(negedge clk);
`endif

    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom_range(5, 0)),
                    RETRY_W'($urandom_range(3, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
